// File: rtl/mult_16.sv
// Sequential 16x16 unsigned shift-add multiplier with a start/done handshake.
// Optional macro MULT_16_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.
module mult_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_in,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [31:0] Result,
  output logic        done
);

  // state  | meaning
  // IDLE   | waiting for a 0->1 edge on init_in
  // RUN    | one multiplier bit per cycle
  // FIN    | publish product, pulse done
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]  state_q,  state_d;
  logic [31:0] mcand_q,  mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [31:0] acc_q,    acc_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic        init_q,   init_d;
  logic [31:0] result_q, result_d;
  logic        done_q,   done_d;
  logic        start;
  logic        last_bit;

  assign start = init_in & ~init_q;

`ifdef MULT_16_EARLY_EXIT_EN
  assign last_bit = (cnt_q == 5'd1) || (mplier_q[15:1] == 15'd0);
`else
  assign last_bit = (cnt_q == 5'd1);
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    init_d   = init_in;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {16'h0000, A};
          mplier_d = B;
          acc_d    = 32'h0;
          cnt_d    = 5'd16;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        // bits shifted out of the top of mcand can never contribute
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 5'd1;
        if (last_bit) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= 32'h0;
      mplier_q <= 16'h0;
      acc_q    <= 32'h0;
      cnt_q    <= 5'd0;
      init_q   <= 1'b0;
      result_q <= 32'h0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      init_q   <= init_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign Result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mult_16.sv
// Directed, table-driven bench for mult_16; latency expectations follow MULT_16_EARLY_EXIT_EN.
module tb_mult_16;

  logic        clk;
  logic        rst;
  logic        init_in;
  logic [15:0] A;
  logic [15:0] B;
  logic [31:0] Result;
  logic        done;

  int checks;
  int failures;

  mult_16 dut (
    .clk     (clk),
    .rst     (rst),
    .init_in (init_in),
    .A       (A),
    .B       (B),
    .Result  (Result),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    int          lat_fixed;
    int          lat_early;
  } vec_t;

  vec_t vecs[9];

  function automatic int pick_lat(input int lat_fixed, input int lat_early);
`ifdef MULT_16_EARLY_EXIT_EN
    return lat_early;
`else
    return lat_fixed;
`endif
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Caller stands just after an edge with init_in already driven high; the next edge is E0.
  // init_in drops after E<hold>; optionally re-pulsed for one cycle around E<inj>.
  task automatic wait_done(input string name, input logic [31:0] res, input int lat,
                           input int hold, input int inj);
    logic [31:0] prev;
    int          seen;
    int          hold_err;
    prev     = Result;
    seen     = -1;
    hold_err = 0;
    for (int k = 0; k <= 40; k++) begin
      tick();
      if (k == hold) init_in = 1'b0;
      if (inj > 0 && k == inj - 1) init_in = 1'b1;
      if (inj > 0 && k == inj) init_in = 1'b0;
      if (k > 0 && done === 1'b1) begin
        seen = k;
        break;
      end
      if (k > 0 && Result !== prev) hold_err++;
    end
    check_int({name, " latency"}, seen, lat);
    check_int({name, " result_held_while_busy"}, hold_err, 0);
    check32({name, " result"}, Result, res);
  endtask

  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] res, input int lat, input int hold, input int inj);
    A       = a;
    B       = b;
    init_in = 1'b1;
    wait_done(name, res, lat, hold, inj);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (done === 1'b1) n++;
    end
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;

    vecs[0] = '{16'h95EC, 16'h00CA, 32'h00764C38, 17, 9};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17, 17};
    vecs[2] = '{16'h1234, 16'h0000, 32'h00000000, 17, 2};
    vecs[3] = '{16'h0000, 16'h8000, 32'h00000000, 17, 17};
    vecs[4] = '{16'h0003, 16'h0005, 32'h0000000F, 17, 4};
    vecs[5] = '{16'h0001, 16'h0001, 32'h00000001, 17, 2};
    vecs[6] = '{16'hABCD, 16'h0100, 32'h00ABCD00, 17, 10};
    vecs[7] = '{16'h1234, 16'h5678, 32'h06260060, 17, 16};
    vecs[8] = '{16'hFFFF, 16'h0001, 32'h0000FFFF, 17, 2};

    rst     = 1'b1;
    init_in = 1'b0;
    A       = 16'h0;
    B       = 16'h0;
    repeat (3) tick();
    check32("reset result", Result, 32'h0);
    check32("reset done", {31'h0, done}, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res,
            pick_lat(vecs[i].lat_fixed, vecs[i].lat_early), 2, 0);
      tick();
      check32($sformatf("vec%0d done_single_pulse", i), {31'h0, done}, 32'h0);
      check32($sformatf("vec%0d result_hold_after", i), Result, vecs[i].res);
      tick();
    end

    // busy-ignore: second start pulse at E5 must be dropped; then back-to-back accept at E18
    do_op("busy", 16'h0101, 16'hFFFF, 32'h0100FEFF, 17, 1, 5);
    do_op("b2b", 16'h0003, 16'h0005, 32'h0000000F, pick_lat(17, 4), 1, 0);
    count_dones(30, n);
    check_int("busy no_extra_done", n, 0);
    check32("busy result_held_idle", Result, 32'h0000000F);

    // reset mid-operation at E8 for two cycles; init_in high across release starts a new op
    A       = 16'h00FF;
    B       = 16'h00FF;
    init_in = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      tick();
      if (k == 1) init_in = 1'b0;
    end
    rst = 1'b1;
    tick();
    check32("midrst result", Result, 32'h0);
    check32("midrst done", {31'h0, done}, 32'h0);
    A       = 16'h0010;
    B       = 16'h0011;
    init_in = 1'b1;
    tick();
    rst = 1'b0;
    wait_done("post_rst_start", 32'h00000110, pick_lat(17, 6), 1, 0);
    count_dones(30, n);
    check_int("midrst no_stale_done", n, 0);

    rst = 1'b1;
    init_in = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    count_dones(25, n);
    check_int("after_rst no_done", n, 0);

    // held start: 40 cycles of init_in high yield exactly one operation
    A       = 16'h0007;
    B       = 16'h0009;
    init_in = 1'b1;
    count_dones(40, n);
    init_in = 1'b0;
    begin
      int n2;
      count_dones(25, n2);
      check_int("held_start done_count", n + n2, 1);
    end
    check32("held_start result", Result, 32'h0000003F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
